// File: rtl/fifo_seq_pkg.sv
// ---------------------------------------------------------------------------
// fifo_seq_pkg
// Shared types and defaults for the FT245 FIFO sequencer.
//   state_t   : sequencer FSM states
//   grant_t   : which path won the last arbitration
//   DEF_*     : default strobe / recovery timing in clk_in cycles
//   upcase()  : folds ASCII 'a'..'z' to 'A'..'Z' (used when
//               FIFO_SEQ_UPCASE_EN is defined in fifo_seq)
// ---------------------------------------------------------------------------
package fifo_seq_pkg;

    localparam int DATA_W         = 7;
    localparam int DEF_RD_CYCLES  = 3;
    localparam int DEF_WR_CYCLES  = 2;
    localparam int DEF_REC_CYCLES = 4;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_STROBE = 3'd1,
        ST_WR_SETUP  = 3'd2,
        ST_WR_STROBE = 3'd3,
        ST_WR_HOLD   = 3'd4,
        ST_RECOVER   = 3'd5
    } state_t;

    typedef enum logic {
        GRANT_RD = 1'b0,
        GRANT_WR = 1'b1
    } grant_t;

    function automatic logic [DATA_W-1:0] upcase(input logic [DATA_W-1:0] b);
        if (b >= 7'h61 && b <= 7'h7A) begin
            return b & ~7'h20;
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_seq_sync2.sv
// ---------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for one asynchronous input.
//   clk_in : system clock
//   reset  : synchronous active-high reset, loads both flops with RST_VAL
//   d      : asynchronous input
//   q      : synchronised output (2 cycles of latency)
// ---------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_in,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk_in) begin
        if (reset) begin
            meta_reg <= RST_VAL;
            q_reg    <= RST_VAL;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/fifo_seq.sv
// ---------------------------------------------------------------------------
// fifo_seq
// Clocked sequencer between an FT245-style USB FIFO and the PIA.
// Reads host bytes into the keyboard port (PA/CA1/CA2) and writes display
// bytes from PB (CB2/CB1) to the FIFO, arbitrating fairly between the two.
//
// Ports
//   clk_in, reset               : clock, synchronous active-high reset
//   fifo_rxf_n, fifo_txe_n      : FIFO status (async, active low)
//   fifo_rd_n, fifo_wr_n        : FIFO strobes (active low, registered)
//   fifo_data_i / _o / _oe      : FIFO data bus in, drive value, drive enable
//   kbd_data, kbd_strobe        : keyboard byte and one-cycle "new byte" pulse
//   kbd_ack                     : keyboard consumed byte (async, rising edge)
//   dsp_data, dsp_valid         : display byte and its valid level (async)
//   dsp_ack                     : one-cycle "byte sent" pulse
//
// Build option: define FIFO_SEQ_UPCASE_EN to fold lower-case ASCII read from
// the FIFO to upper case before it reaches kbd_data. Timing is unchanged.
// ---------------------------------------------------------------------------
module fifo_seq
    import fifo_seq_pkg::*;
#(
    parameter int RD_CYCLES  = DEF_RD_CYCLES,
    parameter int WR_CYCLES  = DEF_WR_CYCLES,
    parameter int REC_CYCLES = DEF_REC_CYCLES
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              fifo_rxf_n,
    input  logic              fifo_txe_n,
    output logic              fifo_rd_n,
    output logic              fifo_wr_n,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic [DATA_W-1:0] fifo_data_o,
    output logic              fifo_data_oe,
    output logic [DATA_W-1:0] kbd_data,
    output logic              kbd_strobe,
    input  logic              kbd_ack,
    input  logic [DATA_W-1:0] dsp_data,
    input  logic              dsp_valid,
    output logic              dsp_ack
);

    localparam int MAX_RW  = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int MAX_CYC = (MAX_RW > REC_CYCLES) ? MAX_RW : REC_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    // Counters load "cycles - 1" and the state ends when they reach zero.
    localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'(WR_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD = CNT_W'(REC_CYCLES - 1);

    // Synchroniser lanes: 0 rxf_n, 1 txe_n, 2 kbd_ack, 3 dsp_valid.
    localparam logic [3:0] SYNC_RST = 4'b0011;

    logic [3:0] sync_in;
    logic [3:0] sync_out;
    logic       rxf_s;
    logic       txe_s;
    logic       kbd_ack_s;
    logic       dsp_valid_s;

    assign sync_in = {dsp_valid, kbd_ack, fifo_txe_n, fifo_rxf_n};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            sync2 #(
                .RST_VAL (SYNC_RST[gi])
            ) u_sync (
                .clk_in (clk_in),
                .reset  (reset),
                .d      (sync_in[gi]),
                .q      (sync_out[gi])
            );
        end
    endgenerate

    assign rxf_s       = sync_out[0];
    assign txe_s       = sync_out[1];
    assign kbd_ack_s   = sync_out[2];
    assign dsp_valid_s = sync_out[3];

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    grant_t             last_grant_reg;
    logic               kbd_full_reg;
    logic               dsp_busy_reg;
    logic               kbd_ack_prev_reg;
    logic               rd_n_reg;
    logic               wr_n_reg;
    logic               oe_reg;
    logic [DATA_W-1:0]  data_o_reg;
    logic [DATA_W-1:0]  kbd_data_reg;
    logic               kbd_strobe_reg;
    logic               dsp_ack_reg;

    logic               rd_ok;
    logic               wr_ok;
    logic [DATA_W-1:0]  kbd_byte;

    assign rd_ok = !rxf_s && !kbd_full_reg;
    assign wr_ok = !txe_s && dsp_valid_s && !dsp_busy_reg;

`ifdef FIFO_SEQ_UPCASE_EN
    assign kbd_byte = upcase(fifo_data_i);
`else
    assign kbd_byte = fifo_data_i;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            cnt_reg          <= '0;
            last_grant_reg   <= GRANT_WR;
            kbd_full_reg     <= 1'b0;
            dsp_busy_reg     <= 1'b0;
            kbd_ack_prev_reg <= 1'b0;
            rd_n_reg         <= 1'b1;
            wr_n_reg         <= 1'b1;
            oe_reg           <= 1'b0;
            data_o_reg       <= '0;
            kbd_data_reg     <= '0;
            kbd_strobe_reg   <= 1'b0;
            dsp_ack_reg      <= 1'b0;
        end else begin
            kbd_strobe_reg   <= 1'b0;
            dsp_ack_reg      <= 1'b0;
            kbd_ack_prev_reg <= kbd_ack_s;

            // Flag clears come first so that a set later in the FSM wins.
            if (kbd_full_reg && kbd_ack_s && !kbd_ack_prev_reg) begin
                kbd_full_reg <= 1'b0;
            end
            if (!dsp_valid_s) begin
                dsp_busy_reg <= 1'b0;
            end

            case (state_reg)
                ST_IDLE: begin
                    // On a tie the path that did not win last time goes first.
                    if (rd_ok && (!wr_ok || last_grant_reg == GRANT_WR)) begin
                        state_reg      <= ST_RD_STROBE;
                        rd_n_reg       <= 1'b0;
                        cnt_reg        <= RD_LOAD;
                        last_grant_reg <= GRANT_RD;
                    end else if (wr_ok) begin
                        state_reg      <= ST_WR_SETUP;
                        data_o_reg     <= dsp_data;
                        oe_reg         <= 1'b1;
                        cnt_reg        <= '0;
                        last_grant_reg <= GRANT_WR;
                    end
                end
                ST_RD_STROBE: begin
                    if (cnt_reg == '0) begin
                        // Last low cycle: the FIFO data is valid now.
                        rd_n_reg       <= 1'b1;
                        kbd_data_reg   <= kbd_byte;
                        kbd_strobe_reg <= 1'b1;
                        kbd_full_reg   <= 1'b1;
                        cnt_reg        <= REC_LOAD;
                        state_reg      <= ST_RECOVER;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_WR_SETUP: begin
                    wr_n_reg  <= 1'b0;
                    cnt_reg   <= WR_LOAD;
                    state_reg <= ST_WR_STROBE;
                end
                ST_WR_STROBE: begin
                    if (cnt_reg == '0) begin
                        wr_n_reg     <= 1'b1;
                        dsp_ack_reg  <= 1'b1;
                        dsp_busy_reg <= 1'b1;
                        cnt_reg      <= '0;
                        state_reg    <= ST_WR_HOLD;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                ST_WR_HOLD: begin
                    oe_reg    <= 1'b0;
                    cnt_reg   <= REC_LOAD;
                    state_reg <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    if (cnt_reg == '0) begin
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign fifo_rd_n    = rd_n_reg;
    assign fifo_wr_n    = wr_n_reg;
    assign fifo_data_oe = oe_reg;
    assign fifo_data_o  = data_o_reg;
    assign kbd_data     = kbd_data_reg;
    assign kbd_strobe   = kbd_strobe_reg;
    assign dsp_ack      = dsp_ack_reg;

endmodule

// File: tb/tb_fifo_seq.sv
// ---------------------------------------------------------------------------
// tb_fifo_seq
// Scoreboard bench for fifo_seq. Host bytes pushed into the FIFO model also
// push the expected keyboard byte; display bytes push the expected FIFO write
// byte. A negedge monitor pops and compares as the DUT produces output and
// checks strobe widths, latency, arbitration order and recovery gaps.
// Define FIFO_SEQ_UPCASE_EN for both files to check the upper-case build.
// ---------------------------------------------------------------------------
module tb_fifo_seq;

    localparam int RD_CYC  = 3;
    localparam int WR_CYC  = 2;
    localparam int REC_CYC = 4;

    logic       clk_in = 1'b0;
    logic       reset = 1'b1;
    logic       fifo_rxf_n = 1'b1;
    logic       fifo_txe_n = 1'b1;
    logic       fifo_rd_n;
    logic       fifo_wr_n;
    logic [6:0] fifo_data_i = '0;
    logic [6:0] fifo_data_o;
    logic       fifo_data_oe;
    logic [6:0] kbd_data;
    logic       kbd_strobe;
    logic       kbd_ack = 1'b0;
    logic [6:0] dsp_data = '0;
    logic       dsp_valid = 1'b0;
    logic       dsp_ack;

    fifo_seq dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .fifo_rxf_n   (fifo_rxf_n),
        .fifo_txe_n   (fifo_txe_n),
        .fifo_rd_n    (fifo_rd_n),
        .fifo_wr_n    (fifo_wr_n),
        .fifo_data_i  (fifo_data_i),
        .fifo_data_o  (fifo_data_o),
        .fifo_data_oe (fifo_data_oe),
        .kbd_data     (kbd_data),
        .kbd_strobe   (kbd_strobe),
        .kbd_ack      (kbd_ack),
        .dsp_data     (dsp_data),
        .dsp_valid    (dsp_valid),
        .dsp_ack      (dsp_ack)
    );

    always #5 clk_in = ~clk_in;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic [6:0] rx_q[$];
    logic [6:0] kbd_q[$];
    logic [6:0] tx_q[$];
    int exp_ack = 0;

    int  rd_count = 0, wr_count = 0, ack_count = 0, strobe_count = 0;
    int  cyc = 0, rxf_fall_cyc = 0;
    bit  check_lat = 0, contention = 0, auto_ack = 1;
    bit  last_kind = 0, have_kind = 0, have_prev_acc = 0;
    int  gap = 0;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    function automatic logic [6:0] kbd_model(input logic [6:0] b);
`ifdef FIFO_SEQ_UPCASE_EN
        if (b >= 7'h61 && b <= 7'h7A) return {b[6], 1'b0, b[4:0]};
`endif
        return b;
    endfunction

    task automatic push_rx(input logic [6:0] b);
        rx_q.push_back(b);
        kbd_q.push_back(kbd_model(b));
    endtask

    task automatic acc_start(input bit kind);
        if (have_prev_acc) chk_val("rec_gap", 32'(gap >= REC_CYC), 1);
        have_prev_acc = 1;
        gap = 0;
        if (contention) begin
            if (have_kind) chk_val("grant_alt", 32'(kind), 32'(!last_kind));
            last_kind = kind;
            have_kind = 1;
        end
    endtask

    // Monitor and FIFO model; samples on the falling edge.
    initial begin
        bit prev_rd = 1, prev_wr = 1, prev_oe = 0, prev_stb = 0, prev_ack = 0;
        int rd_low = 0, wr_low = 0, oe_len = 0;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (reset) begin
                prev_rd = 1; prev_wr = 1; prev_oe = 0; prev_stb = 0; prev_ack = 0;
                rd_low = 0; wr_low = 0; oe_len = 0;
                have_prev_acc = 0; have_kind = 0; gap = 0;
            end else begin
                if (!fifo_rd_n && prev_rd) begin
                    rd_count++;
                    acc_start(0);
                    if (check_lat) begin
                        chk_val("rxf_to_rd", 32'(cyc - rxf_fall_cyc), 3);
                        check_lat = 0;
                    end
                end
                if (!fifo_wr_n && prev_wr) begin
                    wr_count++;
                    acc_start(1);
                    if (tx_q.size() != 0) chk_val("wr_data", 32'(fifo_data_o), 32'(tx_q.pop_front()));
                    else chk_val("wr_unexp", 32'(tx_q.size()), 1);
                end
                if (fifo_rd_n && fifo_wr_n) gap++;

                if (!fifo_rd_n) rd_low++;
                else if (!prev_rd) begin
                    chk_val("rd_len", 32'(rd_low), RD_CYC);
                    rd_low = 0;
                    if (rx_q.size() != 0) void'(rx_q.pop_front());
                end
                if (!fifo_wr_n) wr_low++;
                else if (!prev_wr) begin
                    chk_val("wr_len", 32'(wr_low), WR_CYC);
                    wr_low = 0;
                end
                if (fifo_data_oe) oe_len++;
                else if (prev_oe) begin
                    chk_val("oe_len", 32'(oe_len), WR_CYC + 2);
                    oe_len = 0;
                end

                if (kbd_strobe) begin
                    if (prev_stb) chk_val("kbd_strobe_w", 32'(prev_stb), 0);
                    else begin
                        strobe_count++;
                        if (kbd_q.size() != 0) chk_val("kbd_data", 32'(kbd_data), 32'(kbd_q.pop_front()));
                        else chk_val("kbd_unexp", 32'(kbd_q.size()), 1);
                    end
                end
                if (dsp_ack) begin
                    if (prev_ack) chk_val("dsp_ack_w", 32'(prev_ack), 0);
                    else if (exp_ack > 0) begin
                        exp_ack--;
                        ack_count++;
                        chk_val("ack_hold", {30'd0, fifo_data_oe, fifo_wr_n}, 3);
                    end else chk_val("dsp_ack_unexp", 32'(exp_ack), 1);
                end
                prev_rd = fifo_rd_n; prev_wr = fifo_wr_n; prev_oe = fifo_data_oe;
                prev_stb = kbd_strobe; prev_ack = dsp_ack;
            end
            if (fifo_rxf_n && rx_q.size() != 0) rxf_fall_cyc = cyc;
            fifo_rxf_n  = (rx_q.size() == 0);
            fifo_data_i = (rx_q.size() != 0) ? rx_q[0] : 7'h00;
        end
    end

    // PIA keyboard side: acknowledges each strobed byte when auto_ack allows.
    initial begin
        bit owe = 0;
        forever begin
            @(negedge clk_in);
            if (kbd_strobe) owe = 1;
            if (owe && auto_ack) begin
                kbd_ack = 1'b1;
                repeat (2) @(negedge clk_in);
                kbd_ack = 1'b0;
                owe = 0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rd(input int target);
        for (int i = 0; i < 300 && rd_count < target; i++) @(negedge clk_in);
        if (rd_count < target) chk_val("rd_timeout", 32'(rd_count), 32'(target));
    endtask

    task automatic wait_wr(input int target);
        for (int i = 0; i < 300 && wr_count < target; i++) @(negedge clk_in);
        if (wr_count < target) chk_val("wr_timeout", 32'(wr_count), 32'(target));
    endtask

    task automatic wait_ack(input int target);
        for (int i = 0; i < 300 && ack_count < target; i++) @(negedge clk_in);
        if (ack_count < target) chk_val("ack_timeout", 32'(ack_count), 32'(target));
    endtask

    task automatic send_dsp(input logic [6:0] b);
        int t;
        t = ack_count + 1;
        dsp_data = b;
        tx_q.push_back(b);
        exp_ack++;
        dsp_valid = 1'b1;
        wait_ack(t);
        dsp_valid = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        int base, sbase, i;
        repeat (4) @(posedge clk_in);
        #1;
        chk_val("rst_rd_n", 32'(fifo_rd_n), 1);
        chk_val("rst_wr_n", 32'(fifo_wr_n), 1);
        chk_val("rst_oe", 32'(fifo_data_oe), 0);
        chk_val("rst_data_o", 32'(fifo_data_o), 0);
        chk_val("rst_kbd_data", 32'(kbd_data), 0);
        chk_val("rst_kbd_strobe", 32'(kbd_strobe), 0);
        chk_val("rst_dsp_ack", 32'(dsp_ack), 0);
        reset = 1'b0;
        fifo_txe_n = 1'b0;
        repeat (4) @(negedge clk_in);

        // Single read; second byte must wait for the keyboard ack.
        auto_ack = 0;
        check_lat = 1;
        base = rd_count;
        sbase = strobe_count;
        push_rx(7'h41);
        push_rx(7'h42);
        wait_rd(base + 1);
        repeat (30) @(negedge clk_in);
        chk_val("rd_blocked", 32'(rd_count), 32'(base + 1));
        chk_val("strobe_cnt", 32'(strobe_count), 32'(sbase + 1));
        auto_ack = 1;
        wait_rd(base + 2);
        repeat (15) @(negedge clk_in);
        chk_val("rd_after_ack", 32'(strobe_count), 32'(sbase + 2));

        // Single write; held dsp_valid must not cause a second write.
        base = wr_count;
        dsp_data = 7'h0D;
        tx_q.push_back(7'h0D);
        exp_ack++;
        dsp_valid = 1'b1;
        wait_ack(ack_count + 1);
        repeat (25) @(negedge clk_in);
        chk_val("wr_blocked", 32'(wr_count), 32'(base + 1));
        dsp_valid = 1'b0;
        repeat (4) @(negedge clk_in);
        send_dsp(7'h0E);
        chk_val("wr_rearm", 32'(wr_count), 32'(base + 2));
        repeat (10) @(negedge clk_in);

        // Reset in the second WR_STROBE cycle aborts the write.
        base = wr_count;
        dsp_data = 7'h55;
        tx_q.push_back(7'h55);
        dsp_valid = 1'b1;
        for (i = 0; i < 100 && fifo_wr_n; i++) begin
            @(posedge clk_in);
            #1;
        end
        chk_val("abort_wr_seen", 32'(fifo_wr_n), 0);
        @(posedge clk_in);
        #1;
        reset = 1'b1;
        @(posedge clk_in);
        #1;
        chk_val("abort_wr_n", 32'(fifo_wr_n), 1);
        chk_val("abort_oe", 32'(fifo_data_oe), 0);
        chk_val("abort_ack", 32'(dsp_ack), 0);
        reset = 1'b0;
        dsp_valid = 1'b0;
        repeat (20) @(negedge clk_in);
        chk_val("abort_no_rewr", 32'(wr_count), 32'(base + 1));

        // Case folding (build dependent) and post-reset read latency.
        base = rd_count;
        check_lat = 1;
        push_rx(7'h61);
        push_rx(7'h7B);
        wait_rd(base + 2);
        repeat (15) @(negedge clk_in);

        // Contention: both sides always ready, grants must alternate.
        contention = 1;
        base = rd_count;
        sbase = wr_count;
        for (i = 0; i < 4; i++) push_rx(7'(7'h31 + i));
        for (i = 0; i < 4; i++) send_dsp(7'(7'h50 + i));
        wait_rd(base + 4);
        wait_wr(sbase + 4);
        repeat (20) @(negedge clk_in);
        contention = 0;

        chk_val("kbd_q_left", 32'(kbd_q.size()), 0);
        chk_val("tx_q_left", 32'(tx_q.size()), 0);
        chk_val("ack_left", 32'(exp_ack), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
